// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: one outstanding imem request, result lands in the IF/ID register.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirects raise misalign_exc instead of loading the PC.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [31:0] pc_current
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misalign_exc
`endif
);

   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_hold;
   logic        r_drop;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_instr;

   logic        w_hs;
   logic        w_misalign;
   logic [31:0] w_target;
   logic [31:0] w_pc_next;

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign w_target   = redirect_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= w_misalign;
   end

   assign misalign_exc = r_misalign;
`else
   assign w_misalign = 1'b0;
   assign w_target   = redirect_pc & ~32'h0000_0003;
`endif

   // Request is only presented in FETCH and never while reset is asserted
   assign imem_req_valid = (r_state == S_FETCH) & ~rst;
   assign imem_addr      = r_pc;
   assign w_hs           = imem_req_valid & imem_req_ready;
   assign w_pc_next      = r_pc + 32'(INSTR_BYTES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_hold     <= '0;
         r_drop     <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= NOP_INSTR;
      end else if (redirect_valid) begin
         r_if_valid <= 1'b0;
         r_if_instr <= NOP_INSTR;
         if (!w_misalign) r_pc <= w_target;
         unique case (r_state)
            S_FETCH: begin
               if (w_hs) begin
                  r_state <= S_WAIT;
                  r_drop  <= ~w_misalign;
               end
            end
            S_WAIT: begin
               // A response coinciding with the redirect is consumed here so WAIT cannot deadlock
               if (imem_resp_valid) begin
                  r_state <= S_FETCH;
                  r_drop  <= 1'b0;
               end else if (!w_misalign) begin
                  r_drop  <= 1'b1;
               end
            end
            S_HOLD:  r_state <= S_FETCH;
            default: r_state <= S_FETCH;
         endcase
      end else begin
         if (!stall) r_if_valid <= 1'b0;
         unique case (r_state)
            S_FETCH: begin
               if (w_hs) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  if (r_drop) begin
                     r_drop  <= 1'b0;
                     r_state <= S_FETCH;
                  end else if (!stall) begin
                     r_if_valid <= 1'b1;
                     r_if_pc    <= r_pc;
                     r_if_instr <= imem_resp_data;
                     r_pc       <= w_pc_next;
                     r_state    <= S_FETCH;
                  end else begin
                     r_hold  <= imem_resp_data;
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= r_pc;
                  r_if_instr <= r_hold;
                  r_pc       <= w_pc_next;
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign if_valid   = r_if_valid;
   assign if_pc      = r_if_pc;
   assign if_instr   = r_if_instr;
   assign pc_current = r_pc;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch stage.
- Consumes the branch/jump target produced by adder_pc_imm through the redirect port, and otherwise advances PC by 4.
- Issues one outstanding instruction-memory request at a time and presents the fetched instruction, with its PC, to the IF/ID boundary.
- Handles decode stall, pipeline flush on redirect, and drops stale memory responses.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction word driven on if_instr during reset and after a flush (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  downstream hold; if_* outputs must not change while high.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  target address from adder_pc_imm.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  fetch address; equals pc_current.
- imem_resp_valid  input  1  response data valid, one-cycle pulse.
- imem_resp_data  input  32  instruction word.
- if_valid  output  1  if_pc/if_instr hold a valid instruction.
- if_pc  output  32  PC of the instruction in the IF/ID register.
- if_instr  output  32  instruction in the IF/ID register.
- pc_current  output  32  architectural fetch PC.
- misalign_exc  output  1  present only with MISALIGN_TRAP_EN.

Behaviour:
- Reset (async assert, released on a clk edge):
  - pc_current=RESET_PC, state=FETCH, drop=0, hold buffer empty.
  - imem_req_valid=0 while rst is high; if_valid=0, if_pc=0, if_instr=NOP_INSTR, misalign_exc=0.
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc_current. When imem_req_valid & imem_req_ready, go to WAIT. PC is not advanced yet.
  - WAIT: imem_req_valid=0; wait for imem_resp_valid.
    - Response with drop=1: discard it, clear drop, go to FETCH.
    - Response with drop=0 and stall=0: load if_valid=1, if_pc=pc_current, if_instr=imem_resp_data; pc_current+=4; go to FETCH.
    - Response with drop=0 and stall=1: store the data in the hold buffer; go to HOLD.
  - HOLD: imem_req_valid=0. When stall=0, move the buffer to the IF regs, set pc_current+=4, go to FETCH.
- Bubble: when stall=0 and no instruction is delivered this cycle, if_valid<=0, and if_pc/if_instr hold their last values.
- Stall: while stall=1, if_valid, if_pc and if_instr are frozen. Requests may still be issued in FETCH.
- Redirect (highest priority, any state):
  - pc_current<=redirect_pc and if_valid<=0 on the next edge, even while stall=1.
  - if_instr<=NOP_INSTR.
  - FETCH without handshake: stay in FETCH.
  - FETCH with a handshake in the same cycle: go to WAIT with drop=1.
  - WAIT: set drop=1 and stay in WAIT.
  - HOLD: discard the buffer and go to FETCH.
- Latency: with ready=1 and a 1-cycle memory, one instruction every 2 cycles. The request is at cycle N and the IF register is valid at cycle N+2.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFFFFFC+4 = 32'h00000000.
- Reset mid-operation: an outstanding response arriving after reset is ignored, because state is FETCH and no request is pending.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro:
  - A redirect with redirect_pc[1:0]!=0 does not change pc_current and does not set drop.
  - It flushes if_valid to 0 and pulses misalign_exc=1 for exactly one cycle (registered).
  - All other redirect effects apply.
- Without the macro:
  - The misalign_exc port is absent.
  - redirect_pc[1:0] is forced to 2'b00 before loading pc_current.

Test Plan:
- Reset with RESET_PC=32'h00000100 -> imem_req_valid=0 during rst; first request after release has imem_addr=32'h100; if_valid=0, if_instr=32'h00000013.
- Streaming fetch, ready=1, 1-cycle response, data 32'hA0+n -> if_pc sequence 100,104,108 with matching if_instr, one instruction every 2 cycles.
- stall=1 held 3 cycles while a response arrives -> IF regs frozen; after release, if_instr=held data, then pc_current advances by 4.
- Redirect to 32'h200 while in WAIT -> next response discarded; next request imem_addr=32'h200; if_valid=0 in the cycle after the redirect.
- imem_req_ready=0 for 4 cycles -> imem_req_valid stays 1 with a stable imem_addr. Separately, pc 32'hFFFFFFFC fetch -> next imem_addr=32'h0.
- Redirect to 32'h202:
  - With MISALIGN_TRAP_EN: misalign_exc pulses 1 cycle and pc_current is unchanged.
  - Without it: pc_current=32'h200.
